// File: rtl/ckbuf_clkdiv_ctrl.sv
// ckbuf_clkdiv_ctrl: programmable glitch-free clock divider feeding ckbuf_core_in.
// The divided clock is taken straight from a flop. Ratio changes take effect only
// at period boundaries. Starting and stopping never shorten a high or low phase.
module ckbuf_clkdiv_ctrl #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 div_en,
  input  logic                 div_req,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  output logic                 div_ack,
  output logic                 div_busy,
  output logic                 div_running,
  output logic                 clkdiv_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ratios below 2 cannot produce both a high and a low phase, so they are clamped.
  localparam int                 DEFAULT_LEGAL = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [DIV_WIDTH-1:0] MIN_N     = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEFAULT_N = DIV_WIDTH'(DEFAULT_LEGAL);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] ZERO      = '0;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] n_act_q, n_act_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 out_q, out_d;
  logic                 ack_q, ack_d;
  logic                 running_q, running_d;

  logic [DIV_WIDTH-1:0] req_n;
  logic                 wrap;

  // Clamp an incoming ratio so the divider always sees N >= 2.
  function automatic logic [DIV_WIDTH-1:0] legal_ratio(input logic [DIV_WIDTH-1:0] r);
    return (r < MIN_N) ? MIN_N : r;
  endfunction

  // High phase length for a ratio: floor(N/2), so odd ratios spend the extra cycle low.
  function automatic logic [DIV_WIDTH-1:0] half_of(input logic [DIV_WIDTH-1:0] n);
    return n >> 1;
  endfunction

  // Decode the incoming request and the last count of the current period.
  always_comb begin
    req_n = legal_ratio(div_ratio);
    wrap  = (state_q == RUN) && (cnt_q == (n_act_q - ONE));
  end

  // Next-state logic: phase counter, active ratio, pending request and divided clock.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_act_d    = n_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_d      = out_q;
    ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = ZERO;
        out_d = 1'b0;
        // With no clock running there is no boundary to wait for, so ratios
        // apply at once; a leftover pending value from a stop is flushed here too.
        if (div_req) begin
          n_act_d    = req_n;
          ack_d      = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          n_act_d    = pend_q;
          ack_d      = 1'b1;
          pend_vld_d = 1'b0;
        end
        if (div_en) begin
          state_d = RUN;
          cnt_d   = ZERO;
          out_d   = (ZERO < half_of(n_act_d));
        end
      end

      RUN: begin
        if (wrap) begin
          // Period boundary: the only point a new ratio may take effect.
          if (pend_vld_q) begin
            n_act_d    = pend_q;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
          end
          cnt_d = ZERO;
          if (!div_en) begin
            // Low phase has just completed, so stopping here leaves no runt pulse.
            state_d = IDLE;
            out_d   = 1'b0;
          end else begin
            out_d = (ZERO < half_of(n_act_d));
          end
        end else begin
          cnt_d = cnt_q + ONE;
          out_d = (cnt_d < half_of(n_act_q));
        end
        // A request arriving now (including on the wrap cycle) waits for the next boundary;
        // a later request simply overwrites an earlier one still waiting.
        if (div_req) begin
          pend_d     = req_n;
          pend_vld_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
        out_d   = 1'b0;
      end
    endcase

    running_d = (state_d == RUN);
  end

  // State register; reset forces the divided clock low immediately and drops any pending ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= ZERO;
      n_act_q    <= DEFAULT_N;
      pend_q     <= DEFAULT_N;
      pend_vld_q <= 1'b0;
      out_q      <= 1'b0;
      ack_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_act_q    <= n_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      ack_q      <= ack_d;
      running_q  <= running_d;
    end
  end

  assign clkdiv_out  = out_q;
  assign div_ack     = ack_q;
  assign div_busy    = pend_vld_q;
  assign div_running = running_q;

endmodule
